// File: rtl/lenet_pkg.sv
// Shared types and constants for the LeNet quantize/pool datapath.
package lenet_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} pool_state_e;

  localparam int unsigned DefAccW     = 32;
  localparam int unsigned DefOutW     = 8;
  localparam int unsigned DefMapWidth = 28;
  localparam int unsigned DefNumCh    = 6;
  localparam int unsigned DefShiftW   = 5;

  function automatic longint sat_max(input int unsigned out_w);
    return (longint'(1) <<< (out_w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int unsigned out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/requant_unit.sv
// Bias add, optional round-half-up (QUANT_ROUND_EN), arithmetic shift, ReLU and clamp.
// Purely combinational; sat flags a clamp to a range limit (ReLU zeroing is not saturation).
module requant_unit
  import lenet_pkg::*;
#(
  parameter int unsigned ACC_W   = DefAccW,
  parameter int unsigned OUT_W   = DefOutW,
  parameter int unsigned SHIFT_W = DefShiftW
) (
  input  logic signed [ACC_W-1:0]   acc,
  input  logic signed [ACC_W-1:0]   bias,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      relu_en,
  output logic signed [OUT_W-1:0]   px,
  output logic                      sat
);

  // One extra bit for the bias sum, one more so the rounding increment cannot overflow.
  localparam int unsigned SumW = ACC_W + 2;
  localparam logic signed [SumW-1:0] MaxV = SumW'(sat_max(OUT_W));
  localparam logic signed [SumW-1:0] MinV = SumW'(sat_min(OUT_W));

  logic signed [SumW-1:0] sum;
  logic signed [SumW-1:0] q;

  always_comb begin
    sum = SumW'(acc) + SumW'(bias);
`ifdef QUANT_ROUND_EN
    if (shift != '0) begin
      sum = sum + (SumW'(1) << (shift - SHIFT_W'(1)));
    end
`endif
    q = sum >>> shift;
  end

  always_comb begin
    sat = 1'b0;
    px  = q[OUT_W-1:0];
    if (relu_en && q[SumW-1]) begin
      px = '0;
    end else if (q > MaxV) begin
      px  = MaxV[OUT_W-1:0];
      sat = 1'b1;
    end else if (q < MinV) begin
      px  = MinV[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/quant_pool_stage.sv
// Requantize conv accumulators and 2x2/stride-2 max-pool them, channel-major, one map per channel.
// Build option: define QUANT_ROUND_EN for round-half-up requantization (truncating otherwise).
module quant_pool_stage
  import lenet_pkg::*;
#(
  parameter int unsigned ACC_W     = DefAccW,
  parameter int unsigned OUT_W     = DefOutW,
  parameter int unsigned MAP_WIDTH = DefMapWidth,
  parameter int unsigned NUM_CH    = DefNumCh,
  parameter int unsigned SHIFT_W   = DefShiftW,
  localparam int unsigned ChW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [SHIFT_W-1:0]             shift_in,
  input  logic                           relu_en,
  input  logic [NUM_CH-1:0][ACC_W-1:0]   bias_in,
  input  logic                           valid_in,
  input  logic signed [ACC_W-1:0]        acc_in,
  output logic                           valid_out,
  output logic signed [OUT_W-1:0]        pixel_out,
  output logic [ChW-1:0]                 ch_out,
  output logic                           ch_done,
  output logic                           layer_done,
  output logic                           busy,
  output logic [15:0]                    sat_count
);

  localparam int unsigned Half  = MAP_WIDTH / 2;
  localparam int unsigned PosW  = (MAP_WIDTH > 1) ? $clog2(MAP_WIDTH) : 1;
  localparam int unsigned HalfW = (Half > 1) ? $clog2(Half) : 1;

  if ((MAP_WIDTH < 2) || ((MAP_WIDTH % 2) != 0)) begin : g_bad_map_width
    $error("quant_pool_stage: MAP_WIDTH must be even and >= 2");
  end

  function automatic logic signed [OUT_W-1:0] smax(input logic signed [OUT_W-1:0] a,
                                                    input logic signed [OUT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  pool_state_e                 state_q;
  logic [SHIFT_W-1:0]          shift_q;
  logic                        relu_q;
  logic [NUM_CH-1:0][ACC_W-1:0] bias_q;
  logic [PosW-1:0]             col_q, row_q;
  logic [ChW-1:0]              ch_q;

  logic signed [OUT_W-1:0]     rq_px;
  logic                        rq_sat;

  // Requant register stage, tagged with the pool position of the pixel it carries.
  logic                        s1_valid_q, s1_sat_q, s1_row_odd_q, s1_col_odd_q;
  logic                        s1_ch_last_q, s1_layer_last_q;
  logic signed [OUT_W-1:0]     s1_px_q;
  logic [HalfW-1:0]            s1_half_q;
  logic [ChW-1:0]              s1_ch_q;

  logic signed [OUT_W-1:0]     hold_q;
  logic signed [OUT_W-1:0]     lb_q [Half];

  logic accept, col_last, row_last, ch_last;

  assign accept   = (state_q == StRun) && valid_in;
  assign col_last = (col_q == PosW'(MAP_WIDTH - 1));
  assign row_last = (row_q == PosW'(MAP_WIDTH - 1));
  assign ch_last  = (ch_q == ChW'(NUM_CH - 1));
  assign busy     = (state_q != StIdle);

  requant_unit #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) u_requant (
    .acc     (acc_in),
    .bias    (bias_q[ch_q]),
    .shift   (shift_q),
    .relu_en (relu_q),
    .px      (rq_px),
    .sat     (rq_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      shift_q         <= '0;
      relu_q          <= 1'b0;
      bias_q          <= '0;
      col_q           <= '0;
      row_q           <= '0;
      ch_q            <= '0;
      s1_valid_q      <= 1'b0;
      s1_sat_q        <= 1'b0;
      s1_row_odd_q    <= 1'b0;
      s1_col_odd_q    <= 1'b0;
      s1_ch_last_q    <= 1'b0;
      s1_layer_last_q <= 1'b0;
      s1_px_q         <= '0;
      s1_half_q       <= '0;
      s1_ch_q         <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_px_q         <= rq_px;
        s1_sat_q        <= rq_sat;
        s1_row_odd_q    <= row_q[0];
        s1_col_odd_q    <= col_q[0];
        s1_half_q       <= HalfW'(col_q >> 1);
        s1_ch_q         <= ch_q;
        s1_ch_last_q    <= col_last && row_last;
        s1_layer_last_q <= col_last && row_last && ch_last;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            shift_q <= shift_in;
            relu_q  <= relu_en;
            bias_q  <= bias_in;
            col_q   <= '0;
            row_q   <= '0;
            ch_q    <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (valid_in) begin
            if (col_last) begin
              col_q <= '0;
              if (row_last) begin
                row_q <= '0;
                ch_q  <= ch_last ? '0 : ch_q + 1'b1;
                if (ch_last) state_q <= StDrain;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        StDrain: begin
          if (layer_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= '0;
      for (int i = 0; i < Half; i++) lb_q[i] <= '0;
      valid_out  <= 1'b0;
      pixel_out  <= '0;
      ch_out     <= '0;
      ch_done    <= 1'b0;
      layer_done <= 1'b0;
      sat_count  <= '0;
    end else begin
      valid_out  <= 1'b0;
      ch_done    <= 1'b0;
      layer_done <= 1'b0;
      if (s1_valid_q) begin
        if (!s1_col_odd_q) begin
          hold_q <= s1_px_q;
        end else if (!s1_row_odd_q) begin
          lb_q[s1_half_q] <= smax(hold_q, s1_px_q);
        end else begin
          valid_out  <= 1'b1;
          pixel_out  <= smax(smax(hold_q, s1_px_q), lb_q[s1_half_q]);
          ch_out     <= s1_ch_q;
          ch_done    <= s1_ch_last_q;
          layer_done <= s1_layer_last_q;
        end
      end
      // The pipeline is empty in IDLE, so clearing on start never races an increment.
      if ((state_q == StIdle) && start) begin
        sat_count <= '0;
      end else if (s1_valid_q && s1_sat_q && (sat_count != 16'hFFFF)) begin
        sat_count <= sat_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_quant_pool_stage.sv
// Scoreboard bench for quant_pool_stage (4x4 maps, two channels).
module tb_quant_pool_stage;

  localparam int MW   = 4;
  localparam int NCH  = 2;
  localparam int AW   = 32;
  localparam int OW   = 8;
  localparam int SW   = 5;
  localparam int NPIX = MW * MW;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        start = 1'b0;
  logic [SW-1:0]               shift_in = '0;
  logic                        relu_en = 1'b0;
  logic [NCH-1:0][AW-1:0]      bias_in = '0;
  logic                        valid_in = 1'b0;
  logic signed [AW-1:0]        acc_in = '0;
  logic                        valid_out;
  logic signed [OW-1:0]        pixel_out;
  logic [0:0]                  ch_out;
  logic                        ch_done, layer_done, busy;
  logic [15:0]                 sat_count;

  quant_pool_stage #(
    .ACC_W     (AW),
    .OUT_W     (OW),
    .MAP_WIDTH (MW),
    .NUM_CH    (NCH),
    .SHIFT_W   (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .shift_in   (shift_in),
    .relu_en    (relu_en),
    .bias_in    (bias_in),
    .valid_in   (valid_in),
    .acc_in     (acc_in),
    .valid_out  (valid_out),
    .pixel_out  (pixel_out),
    .ch_out     (ch_out),
    .ch_done    (ch_done),
    .layer_done (layer_done),
    .busy       (busy),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    longint px;
    longint ch;
    bit     cd;
    bit     ld;
    longint cyc;
  } exp_t;

  exp_t sb[$];
  int   stim[NCH*NPIX];
  int   sat_model;

  function automatic int model_q(input int acc, input int bias, input int sh, input bit relu,
                                 output bit sat);
    longint s;
    sat = 1'b0;
    s = longint'(acc) + longint'(bias);
`ifdef QUANT_ROUND_EN
    if (sh > 0) s = s + (longint'(1) <<< (sh - 1));
`endif
    s = s >>> sh;
    if (relu && s < 0) return 0;
    if (s > 127) begin sat = 1'b1; return 127; end
    if (s < -128) begin sat = 1'b1; return -128; end
    return int'(s);
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Output monitor: pops the scoreboard on every valid_out, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (valid_out) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_out", valid_out, 0);
          end else begin
            e = sb.pop_front();
            check_eq("pixel", pixel_out, e.px);
            check_eq("ch_out", ch_out, e.ch);
            check_eq("ch_done", ch_done, e.cd);
            check_eq("layer_done", layer_done, e.ld);
            check_eq("latency", cyc, e.cyc + 2);
          end
        end else begin
          check_eq("stray_done", {ch_done, layer_done}, 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // abort_after >= 0: stop after that many inputs, reset, and poke valid_in while IDLE.
  task automatic run_layer(input int sh, input bit relu, input int b0, input int b1,
                           input int gap_max, input bit start_glitch, input bit drain_poke,
                           input int abort_after);
    int q[NCH*NPIX];
    bit s;
    int n;
    int base;
    int pooled;
    sat_model = 0;
    for (int i = 0; i < NCH * NPIX; i++) begin
      q[i] = model_q(stim[i], (i < NPIX) ? b0 : b1, sh, relu, s);
      sat_model += int'(s);
    end
    shift_in   = SW'(sh);
    relu_en    = relu;
    bias_in[0] = b0;
    bias_in[1] = b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      for (int idx = 0; idx < NPIX; idx++) begin
        if (abort_after >= 0 && n == abort_after) begin
          repeat (4) tick();
          check_eq("abort_drained", sb.size(), 0);
          rst = 1'b1;
          tick();
          rst = 1'b0;
          check_eq("rst_busy", busy, 0);
          check_eq("rst_sat", sat_count, 0);
          check_eq("rst_valid", valid_out, 0);
          valid_in = 1'b1;
          acc_in   = 77;
          repeat (3) tick();
          valid_in = 1'b0;
          repeat (3) tick();
          return;
        end
        base     = ch * NPIX;
        valid_in = 1'b1;
        acc_in   = stim[base + idx];
        if (start_glitch && ch == 0 && idx == 8) start = 1'b1;
        if ((idx / MW) % 2 == 1 && (idx % MW) % 2 == 1) begin
          pooled = max4(q[base + idx - MW - 1], q[base + idx - MW],
                        q[base + idx - 1], q[base + idx]);
          sb.push_back('{px: pooled, ch: ch, cd: (idx == NPIX - 1),
                         ld: (idx == NPIX - 1) && (ch == NCH - 1), cyc: cyc});
        end
        n++;
        tick();
        valid_in = 1'b0;
        start    = 1'b0;
        repeat ($urandom_range(0, gap_max)) tick();
      end
    end
    if (drain_poke) begin
      valid_in = 1'b1;
      acc_in   = 99;
      start    = 1'b1;
      tick();
      valid_in = 1'b0;
      start    = 1'b0;
    end
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    check_eq("drain_timeout", sb.size(), 0);
    check_eq("sat_count", sat_count, sat_model);
    tick();
    check_eq("idle_busy", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_valid_out", valid_out, 0);
    check_eq("reset_pixel_out", pixel_out, 0);
    check_eq("reset_ch_out", ch_out, 0);
    check_eq("reset_ch_done", ch_done, 0);
    check_eq("reset_layer_done", layer_done, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_sat_count", sat_count, 0);
    rst = 1'b0;
    tick();

    // Ramp 0..15 per channel, pass-through: pools 5,7,13,15.
    for (int i = 0; i < NCH * NPIX; i++) stim[i] = i % NPIX;
    run_layer(0, 1'b1, 0, 0, 0, 1'b0, 1'b0, -1);

    // Constant 15 with per-channel bias 10 / -20 under ReLU: 25s then 0s.
    for (int i = 0; i < NCH * NPIX; i++) stim[i] = 15;
    run_layer(0, 1'b1, 10, -20, 0, 1'b0, 1'b0, -1);

    // Saturation: +1000 and -1000 at shift 2, without and with ReLU.
    for (int i = 0; i < NCH * NPIX; i++) stim[i] = 0;
    stim[0]    = 1000;
    stim[NPIX] = -1000;
    run_layer(2, 1'b0, 0, 0, 0, 1'b0, 1'b0, -1);
    run_layer(2, 1'b1, 0, 0, 0, 1'b0, 1'b0, -1);

    // Rounding: +5 and -5 at shift 1 dominate their windows of -100s.
    for (int i = 0; i < NPIX; i++) stim[i] = 0;
    stim[0] = 5;  stim[1] = -100; stim[4] = -100; stim[5] = -100;
    stim[2] = -5; stim[3] = -100; stim[6] = -100; stim[7] = -100;
    for (int i = NPIX; i < NCH * NPIX; i++) stim[i] = int'($urandom_range(0, 4000)) - 2000;
    run_layer(1, 1'b0, 0, 0, 0, 1'b0, 1'b0, -1);

    // Gapped stream with a mid-channel reset, then a clean rerun.
    for (int i = 0; i < NCH * NPIX; i++) stim[i] = int'($urandom_range(0, 4000)) - 2000;
    run_layer(3, 1'b0, 7, -3, 3, 1'b0, 1'b0, 7);
    run_layer(3, 1'b0, 7, -3, 3, 1'b0, 1'b0, -1);

    // start pulsed mid-RUN, valid_in and start poked in DRAIN.
    run_layer(3, 1'b0, 7, -3, 1, 1'b1, 1'b1, -1);

    // Back-to-back layer started right after the previous one finished.
    run_layer(0, 1'b1, 0, 0, 0, 1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
